// File: rtl/pellet_map.sv
// -----------------------------------------------------------------------------
// pellet_map
//   Writable per-tile pellet store. After reset, or on an init_req pulse, it
//   walks every tile once, one tile per clock, in row-major order. For each
//   tile it looks the wall bit up through the external maze wall table and
//   stores pellet = ~wall. Once the sweep is done it serves renderer reads and
//   Pac-Man eat requests, tracks how many pellets remain, and flags level clear.
//
// Ports
//   clk, rst            : single clock; asynchronous active-high reset
//   init_req            : one-cycle pulse, refill the map from the wall table
//   wall_row/wall_col   : tile currently being fetched from the wall table
//   wall_data           : wall bit for (wall_row, wall_col), same cycle
//   rd_row/rd_col       : renderer read coordinates
//   rd_pellet           : pellet at the read tile, one cycle later
//   eat_valid/row/col   : eat request for one tile
//   eat_ack             : one-cycle pulse, a pellet was present and is now gone
//   pellets_left        : pellets remaining in the map
//   level_clear         : map ready and no pellets left
//   busy                : sweep in progress
// -----------------------------------------------------------------------------
module pellet_map #(
    parameter int ROWS  = 31,
    parameter int COLS  = 28,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    output logic [4:0]       wall_row,
    output logic [4:0]       wall_col,
    input  logic             wall_data,
    input  logic [4:0]       rd_row,
    input  logic [4:0]       rd_col,
    output logic             rd_pellet,
    input  logic             eat_valid,
    input  logic [4:0]       eat_row,
    input  logic [4:0]       eat_col,
    output logic             eat_ack,
    output logic [CNT_W-1:0] pellets_left,
    output logic             level_clear,
    output logic             busy
);

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [4:0] ROW_LIM  = 5'(ROWS);
    localparam logic [4:0] COL_LIM  = 5'(COLS);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [4:0] COL_LAST = 5'(COLS - 1);

    state_t           state, state_nx;
    logic [4:0]       ptr_row, ptr_col;
    logic [4:0]       ptr_row_nx, ptr_col_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ack_p1, ack_nx;
    logic             rdp_p1, rdp_nx;
    logic             lvl_p1, lvl_nx;

    // Pellet bits are data: never reset, only meaningful after a full sweep.
    logic [COLS-1:0]  pellet_q [ROWS];

    logic             sweep_we;
    logic             eat_hit;
    logic             eat_ok;
    logic             rd_ok;
    logic             eat_bit;
    logic             rd_bit;

    // Range-checked array lookups; out-of-range coordinates read as no pellet.
    always_comb begin
        eat_ok  = (eat_row < ROW_LIM) && (eat_col < COL_LIM);
        rd_ok   = (rd_row < ROW_LIM) && (rd_col < COL_LIM);
        eat_bit = 1'b0;
        rd_bit  = 1'b0;
        if (eat_ok) begin
            eat_bit = pellet_q[eat_row][eat_col];
        end
        if (rd_ok) begin
            rd_bit = pellet_q[rd_row][rd_col];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx   = state;
        ptr_row_nx = ptr_row;
        ptr_col_nx = ptr_col;
        cnt_nx     = cnt;
        ack_nx     = 1'b0;
        sweep_we   = 1'b0;
        eat_hit    = 1'b0;
        // Reads sample the array before any eat write lands this cycle.
        rdp_nx     = (state == READY) && rd_bit;

        case (state)
            SWEEP: begin
                if (init_req) begin
                    // Restart: the partial sweep so far is simply overwritten.
                    ptr_row_nx = '0;
                    ptr_col_nx = '0;
                    cnt_nx     = '0;
                end else begin
                    sweep_we = 1'b1;
                    cnt_nx   = cnt + CNT_W'(!wall_data);
                    if (ptr_col == COL_LAST) begin
                        ptr_col_nx = '0;
                        if (ptr_row == ROW_LAST) begin
                            ptr_row_nx = '0;
                            state_nx   = READY;
                        end else begin
                            ptr_row_nx = ptr_row + 5'd1;
                        end
                    end else begin
                        ptr_col_nx = ptr_col + 5'd1;
                    end
                end
            end

            READY: begin
                if (init_req) begin
                    // init_req outranks a simultaneous eat.
                    state_nx   = SWEEP;
                    ptr_row_nx = '0;
                    ptr_col_nx = '0;
                    cnt_nx     = '0;
                end else if (eat_valid && eat_ok && eat_bit && (cnt != '0)) begin
                    eat_hit = 1'b1;
                    ack_nx  = 1'b1;
                    cnt_nx  = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nx = SWEEP;
            end
        endcase

        // Looks at the next count so the flag rises together with the last ack.
        lvl_nx = (state_nx == READY) && (cnt_nx == '0);
    end

    // ---- control register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SWEEP;
            ptr_row <= '0;
            ptr_col <= '0;
            cnt     <= '0;
            ack_p1  <= 1'b0;
            rdp_p1  <= 1'b0;
            lvl_p1  <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr_row <= ptr_row_nx;
            ptr_col <= ptr_col_nx;
            cnt     <= cnt_nx;
            ack_p1  <= ack_nx;
            rdp_p1  <= rdp_nx;
            lvl_p1  <= lvl_nx;
        end
    end

    // ---- pellet array write stage ----
    // Sweep writes and eat writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            pellet_q[ptr_row][ptr_col] <= !wall_data;
        end
        if (eat_hit) begin
            pellet_q[eat_row][eat_col] <= 1'b0;
        end
    end

    assign wall_row     = ptr_row;
    assign wall_col     = ptr_col;
    assign busy         = (state == SWEEP);
    assign rd_pellet    = rdp_p1;
    assign eat_ack      = ack_p1;
    assign pellets_left = cnt;
    assign level_clear  = lvl_p1;

endmodule

// File: tb/tb_pellet_map.sv
module tb_pellet_map;

    localparam int ROWS  = 31;
    localparam int COLS  = 28;
    localparam int CNT_W = 10;
    localparam int TILES = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_req;
    logic [4:0]       wall_row, wall_col;
    logic             wall_data;
    logic [4:0]       rd_row, rd_col;
    logic             rd_pellet;
    logic             eat_valid;
    logic [4:0]       eat_row, eat_col;
    logic             eat_ack;
    logic [CNT_W-1:0] pellets_left;
    logic             level_clear;
    logic             busy;

    logic maze [ROWS][COLS];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign wall_data = (int'(wall_row) < ROWS && int'(wall_col) < COLS) ?
                       maze[wall_row][wall_col] : 1'b1;

    pellet_map #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .wall_row(wall_row), .wall_col(wall_col), .wall_data(wall_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_pellet(rd_pellet),
        .eat_valid(eat_valid), .eat_row(eat_row), .eat_col(eat_col),
        .eat_ack(eat_ack), .pellets_left(pellets_left),
        .level_clear(level_clear), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tile map as a plain 2-D bit array, the sweep as a
    // linear tile index, everything updated at the clock edge.
    // ------------------------------------------------------------------
    bit m_map [ROWS][COLS];
    bit m_busy = 1'b1;
    bit m_ack  = 1'b0;
    bit m_rd   = 1'b0;
    bit m_lvl  = 1'b0;
    int m_idx  = 0;
    int m_cnt  = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b1; m_idx = 0; m_cnt = 0;
                m_ack = 1'b0; m_rd = 1'b0; m_lvl = 1'b0;
            end else begin
                int r, c;
                m_ack = 1'b0;
                m_rd  = 1'b0;
                if (!m_busy && int'(rd_row) < ROWS && int'(rd_col) < COLS)
                    m_rd = m_map[rd_row][rd_col];
                if (init_req) begin
                    m_busy = 1'b1; m_idx = 0; m_cnt = 0;
                end else if (m_busy) begin
                    r = m_idx / COLS;
                    c = m_idx % COLS;
                    m_map[r][c] = !maze[r][c];
                    if (!maze[r][c]) m_cnt++;
                    m_idx++;
                    if (m_idx == TILES) begin
                        m_busy = 1'b0;
                        m_idx  = 0;
                    end
                end else if (eat_valid && int'(eat_row) < ROWS && int'(eat_col) < COLS) begin
                    if (m_map[eat_row][eat_col]) begin
                        m_map[eat_row][eat_col] = 1'b0;
                        m_cnt--;
                        m_ack = 1'b1;
                    end
                end
                m_lvl = !m_busy && (m_cnt == 0);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_busy",         busy,         m_busy);
                chk("cyc_pellets_left", pellets_left, m_cnt);
                chk("cyc_eat_ack",      eat_ack,      m_ack);
                chk("cyc_rd_pellet",    rd_pellet,    m_rd);
                chk("cyc_level_clear",  level_clear,  m_lvl);
                chk("cyc_wall_row",     wall_row,     m_idx / COLS);
                chk("cyc_wall_col",     wall_col,     m_idx % COLS);
            end
        end
    end

    // Border walls, random interior, (1,1) and (5,5) always pellets.
    task automatic build_maze(output int n);
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1)
                    maze[r][c] = 1'b1;
                else
                    maze[r][c] = ($urandom_range(0, 2) == 0);
            end
        maze[1][1] = 1'b0;
        maze[5][5] = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!maze[r][c]) n++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges while busy; bounded so a stuck sweep still ends.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            step();
            n++;
        end
    endtask

    task automatic rand_phase(input int cycles, input bit allow_init);
        for (int i = 0; i < cycles; i++) begin
            rd_row    = 5'($urandom_range(0, 31));
            rd_col    = 5'($urandom_range(0, 31));
            eat_valid = 1'($urandom_range(0, 1));
            eat_row   = 5'($urandom_range(0, ROWS));
            eat_col   = 5'($urandom_range(0, COLS));
            init_req  = allow_init && ($urandom_range(0, 299) == 0);
            step();
        end
        init_req  = 1'b0;
        eat_valid = 1'b0;
    endtask

    int n_gold, n2, bc, acks, exp_acks;

    initial begin
        rst = 1'b0; init_req = 1'b0; eat_valid = 1'b0;
        eat_row = '0; eat_col = '0; rd_row = '0; rd_col = '0;
        build_maze(n_gold);
        #1 rst = 1'b1;
        step();
        chk("rst_busy", busy, 1);
        chk("rst_pellets_left", pellets_left, 0);
        chk("rst_eat_ack", eat_ack, 0);
        chk("rst_rd_pellet", rd_pellet, 0);
        chk("rst_level_clear", level_clear, 0);
        chk("rst_wall_row", wall_row, 0);
        chk("rst_wall_col", wall_col, 0);

        // 1: first sweep
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        wait_sweep(bc);
        chk("sweep_len", bc, 868);
        chk("sweep_count", pellets_left, n_gold);
        rd_row = 5'd1; rd_col = 5'd1; step();
        chk("read_1_1", rd_pellet, 1);
        rd_row = 5'd0; rd_col = 5'd0; step();
        chk("read_0_0", rd_pellet, 0);

        // 2: eat, re-eat, eat a wall
        eat_valid = 1'b1; eat_row = 5'd1; eat_col = 5'd1; step();
        chk("eat_1_1_ack", eat_ack, 1);
        chk("eat_1_1_count", pellets_left, n_gold - 1);
        step();
        chk("reeat_1_1_ack", eat_ack, 0);
        chk("reeat_1_1_count", pellets_left, n_gold - 1);
        eat_row = 5'd0; eat_col = 5'd0; step();
        chk("eat_wall_ack", eat_ack, 0);
        eat_valid = 1'b0;

        // 3: read-before-write on the same tile
        rd_row = 5'd5; rd_col = 5'd5;
        eat_valid = 1'b1; eat_row = 5'd5; eat_col = 5'd5; step();
        chk("rbw_read", rd_pellet, 1);
        chk("rbw_ack", eat_ack, 1);
        eat_valid = 1'b0; step();
        chk("rbw_read_after", rd_pellet, 0);

        rand_phase(1500, 1'b0);

        // 6 (READY part): out-of-range coordinates
        eat_valid = 1'b1; eat_row = 5'd31; eat_col = 5'd0; step();
        chk("eat_oob_ack", eat_ack, 0);
        eat_valid = 1'b0;
        rd_row = 5'd0; rd_col = 5'd28; step();
        chk("read_oob", rd_pellet, 0);

        // 4: clear the level
        exp_acks = m_cnt;
        acks = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!maze[r][c]) begin
                    eat_valid = 1'b1; eat_row = 5'(r); eat_col = 5'(c);
                    step();
                    if (eat_ack) acks++;
                end
        eat_valid = 1'b0;
        chk("clear_acks", acks, exp_acks);
        chk("clear_count", pellets_left, 0);
        chk("clear_level", level_clear, 1);

        build_maze(n2);
        init_req = 1'b1; step(); init_req = 1'b0;
        chk("init_level_clear", level_clear, 0);
        chk("init_busy", busy, 1);
        chk("init_count", pellets_left, 0);
        // 6 (busy part): eats ignored during the sweep
        eat_valid = 1'b1; eat_row = 5'd1; eat_col = 5'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("eat_busy_ack", eat_ack, 0);
        end
        eat_valid = 1'b0;
        wait_sweep(bc);
        chk("resweep_len", bc + 5, 868);
        chk("resweep_count", pellets_left, n2);
        rd_row = 5'd1; rd_col = 5'd1; step();
        chk("resweep_read_1_1", rd_pellet, 1);

        // 5: async reset in the middle of a sweep
        init_req = 1'b1; step(); init_req = 1'b0;
        repeat (399) step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1);
        chk("midrst_count", pellets_left, 0);
        chk("midrst_ack", eat_ack, 0);
        chk("midrst_rd", rd_pellet, 0);
        chk("midrst_level", level_clear, 0);
        chk("midrst_wall_row", wall_row, 0);
        chk("midrst_wall_col", wall_col, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_sweep(bc);
        chk("postrst_sweep_len", bc, 868);
        chk("postrst_count", pellets_left, n2);

        // init_req during a sweep restarts it
        init_req = 1'b1; step(); init_req = 1'b0;
        repeat (300) step();
        init_req = 1'b1; step(); init_req = 1'b0;
        wait_sweep(bc);
        chk("restart_sweep_len", bc, 868);
        chk("restart_count", pellets_left, n2);

        rand_phase(4000, 1'b1);
        wait_sweep(bc);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
